// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding, default parameters and byte-lane helper for the SRAM burst model
package sram_pkg;
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT, WR_DONE} state_t;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 17;
  localparam int DEF_DEPTH = 512;
  localparam int DEF_READ_LATENCY = 3;
  localparam int DEF_WRITE_LATENCY = 2;
  localparam int DEF_BURST_LEN = 2;
  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/sram_byte_array.sv
// sram_byte_array: DEPTH x DATA_WIDTH storage with per-byte synchronous write and asynchronous read
module sram_byte_array import sram_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(DEPTH)-1:0]      wr_idx,
  input  logic [lanes(DATA_WIDTH)-1:0]  be_n,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0]         rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < lanes(DATA_WIDTH); i++)
      if (we && !be_n[i]) mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[rd_idx];
endmodule

// File: rtl/sram_burst_model.sv
// sram_burst_model: cycle-accurate SRAM with counted latency, byte enables, read bursts and ready/busy handshake
module sram_burst_model import sram_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int WRITE_LATENCY = DEF_WRITE_LATENCY,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sram_ce_n,
  input  logic                          sram_we_n,
  input  logic [lanes(DATA_WIDTH)-1:0]  sram_be_n,
  input  logic [ADDR_WIDTH-1:0]         sram_address,
  inout  wire  [DATA_WIDTH-1:0]         sram_dq,
  output logic                          sram_ready,
  output logic                          sram_busy
);
  localparam int IW = $clog2(DEPTH);
  localparam int NB = lanes(DATA_WIDTH);
  localparam int CW = 16;
  localparam logic [CW-1:0] RL = CW'(READ_LATENCY);
  localparam logic [CW-1:0] WL = CW'(WRITE_LATENCY);
  localparam logic [CW-1:0] BL = CW'(BURST_LEN);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d, beat, beat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NB-1:0] be_q, be_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d, dout_q, dout_d, rd_data;
  logic ready_d, oe_q, oe_d, mem_we;
  sram_byte_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_array (
    .clk(clk),
    .we(mem_we),
    .wr_idx(IW'(addr_q)),
    .be_n(be_q),
    .wdata(wd_q),
    .rd_idx(IW'(addr_q + ADDR_WIDTH'(beat))),
    .rdata(rd_data)
  );
  assign sram_dq = oe_q ? dout_q : 'z;
  assign sram_busy = state != IDLE;
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    be_q <= be_d;
    wd_q <= wd_d;
    dout_q <= dout_d;
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      beat <= '0;
      sram_ready <= 1'b0;
      oe_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      beat <= beat_d;
      sram_ready <= ready_d;
      oe_q <= oe_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt + 1'b1;
    beat_d = beat;
    addr_d = addr_q;
    be_d = be_q;
    wd_d = wd_q;
    dout_d = dout_q;
    ready_d = 1'b0;
    oe_d = 1'b0;
    mem_we = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = CW'(1);
        beat_d = '0;
        if (!sram_ce_n) begin
          state_d = sram_we_n ? RD_WAIT : WR_WAIT;
          addr_d = sram_address;
          be_d = sram_be_n;
          wd_d = sram_dq;
        end
      end
      RD_WAIT: if (cnt == RL) begin
        state_d = RD_BURST;
        beat_d = CW'(1);
        ready_d = 1'b1;
        oe_d = 1'b1;
        dout_d = rd_data;
      end
      RD_BURST: if (beat == BL) state_d = IDLE;
      else begin
        beat_d = beat + 1'b1;
        ready_d = 1'b1;
        oe_d = 1'b1;
        dout_d = rd_data;
      end
      WR_WAIT: if (cnt == WL) begin
        state_d = WR_DONE;
        mem_we = !rst;
        ready_d = 1'b1;
      end
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sram_burst_model.sv
// tb_sram_burst_model: scoreboard bench driving a default and a narrow/short-latency model instance
module tb_sram_burst_model;
  typedef struct {int cyc; logic [31:0] d; bit rd;} exp_t;
  logic clk = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic rst [2];
  logic ce_n [2];
  logic we_n [2];
  logic drv [2];
  logic [16:0] addr [2];
  logic [3:0] be [2];
  logic [31:0] wd [2];
  int bfrom [2];
  int buntil [2];
  exp_t q [2][$];
  wire [31:0] dq_a;
  wire [15:0] dq_b;
  logic rdy_a, rdy_b, bsy_a, bsy_b;
  assign dq_a = drv[0] ? wd[0] : 'z;
  assign dq_b = drv[1] ? wd[1][15:0] : 'z;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sram_burst_model dut_a (
    .clk(clk), .rst(rst[0]), .sram_ce_n(ce_n[0]), .sram_we_n(we_n[0]),
    .sram_be_n(be[0]), .sram_address(addr[0]), .sram_dq(dq_a),
    .sram_ready(rdy_a), .sram_busy(bsy_a)
  );
  sram_burst_model #(.DATA_WIDTH(16), .ADDR_WIDTH(17), .DEPTH(64), .READ_LATENCY(1),
    .WRITE_LATENCY(2), .BURST_LEN(4)) dut_b (
    .clk(clk), .rst(rst[1]), .sram_ce_n(ce_n[1]), .sram_we_n(we_n[1]),
    .sram_be_n(be[1][1:0]), .sram_address(addr[1]), .sram_dq(dq_b),
    .sram_ready(rdy_b), .sram_busy(bsy_b)
  );
  function automatic int rl(input int s); return s != 0 ? 1 : 3; endfunction
  function automatic int wl(input int s); return 2; endfunction
  function automatic int bl(input int s); return s != 0 ? 4 : 2; endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  task automatic mon(input int s, input logic rdy, input logic bsy, input logic [31:0] dq, input bit isz);
    exp_t e;
    string p;
    p = s != 0 ? "b" : "a";
    chk($sformatf("%s_busy", p), {31'b0, bsy}, {31'b0, cyc >= bfrom[s] && cyc < buntil[s]});
    if (q[s].size() != 0 && q[s][0].cyc < cyc) begin
      e = q[s].pop_front();
      chk($sformatf("%s_ready_missed_cycle", p), 32'(cyc), 32'(e.cyc));
    end
    if (rdy) begin
      if (q[s].size() == 0) chk($sformatf("%s_spurious_ready", p), {31'b0, rdy}, 32'd0);
      else begin
        e = q[s].pop_front();
        chk($sformatf("%s_ready_cycle", p), 32'(cyc), 32'(e.cyc));
        if (e.rd) chk($sformatf("%s_read_data", p), dq, e.d);
        else chk($sformatf("%s_dq_z_on_write", p), {31'b0, isz}, 32'd1);
      end
    end else if (!drv[s]) chk($sformatf("%s_dq_z_idle", p), {31'b0, isz}, 32'd1);
  endtask
  always @(negedge clk) begin
    mon(0, rdy_a, bsy_a, dq_a, dq_a === 32'hzzzzzzzz);
    mon(1, rdy_b, bsy_b, {16'h0, dq_b}, dq_b === 16'hzzzz);
  end
  task automatic req(input int s, input bit wr, input logic [16:0] a, input logic [3:0] be_v,
                     input logic [31:0] d, input logic [31:0] e0, input logic [31:0] e1,
                     input logic [31:0] e2, input logic [31:0] e3, input bit hold, input bit abort);
    int t0;
    exp_t e;
    logic [31:0] ev [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    @(negedge clk);
    ce_n[s] = 0; we_n[s] = !wr; addr[s] = a; be[s] = be_v; wd[s] = d; drv[s] = wr;
    t0 = cyc + 1;
    bfrom[s] = t0;
    if (abort) buntil[s] = t0 + 1;
    else if (wr) begin
      buntil[s] = t0 + wl(s) + 1;
      e.cyc = t0 + wl(s); e.d = d; e.rd = 0;
      q[s].push_back(e);
    end else begin
      buntil[s] = t0 + rl(s) + bl(s);
      for (int k = 0; k < bl(s); k++) begin
        e.cyc = t0 + rl(s) + k; e.d = ev[k]; e.rd = 1;
        q[s].push_back(e);
      end
    end
    @(posedge clk); #1;
    drv[s] = 0; we_n[s] = 1;
    if (!hold) ce_n[s] = 1;
    if (abort) begin
      @(negedge clk); rst[s] = 1;
      @(posedge clk); #1; rst[s] = 0;
    end
    while (hold && ce_n[s] == 0) begin
      @(negedge clk);
      addr[s] = addr[s] + 1;
      if (cyc >= buntil[s] - 1) ce_n[s] = 1;
    end
    while (cyc < buntil[s]) begin @(posedge clk); #1; end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1; ce_n[s] = 1; we_n[s] = 1; drv[s] = 0; addr[s] = '0; be[s] = 4'hF; wd[s] = '0;
      bfrom[s] = 0; buntil[s] = 0;
    end
    repeat (2) @(posedge clk);
    #1; rst[0] = 0; rst[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    req(0, 1, 17'd6, 4'h0, 32'h66666666, 0, 0, 0, 0, 0, 0);
    req(0, 1, 17'd5, 4'h0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    req(0, 0, 17'd5, 4'hF, 0, 32'hDEADBEEF, 32'h66666666, 0, 0, 0, 0);
    req(0, 1, 17'd9, 4'h0, 32'h11223344, 0, 0, 0, 0, 0, 0);
    req(0, 1, 17'd10, 4'h0, 32'h10101010, 0, 0, 0, 0, 0, 0);
    req(0, 1, 17'd9, 4'b1010, 32'hAABBCCDD, 0, 0, 0, 0, 0, 0);
    req(0, 0, 17'd9, 4'hF, 0, 32'h11BB33DD, 32'h10101010, 0, 0, 0, 0);
    req(0, 1, 17'd511, 4'h0, 32'h0000000A, 0, 0, 0, 0, 0, 0);
    req(0, 1, 17'd0, 4'h0, 32'h0000000B, 0, 0, 0, 0, 0, 0);
    req(0, 1, 17'd1, 4'h0, 32'h0000000C, 0, 0, 0, 0, 0, 0);
    req(0, 0, 17'd511, 4'hF, 0, 32'h0000000A, 32'h0000000B, 0, 0, 0, 0);
    req(0, 0, 17'h200, 4'hF, 0, 32'h0000000B, 32'h0000000C, 0, 0, 0, 0);
    req(0, 0, 17'd5, 4'hF, 0, 32'hDEADBEEF, 32'h66666666, 0, 0, 1, 0);
    req(0, 0, 17'd5, 4'hF, 0, 0, 0, 0, 0, 0, 1);
    req(0, 1, 17'd9, 4'h0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1);
    req(0, 0, 17'd9, 4'hF, 0, 32'h11BB33DD, 32'h10101010, 0, 0, 0, 0);
    req(0, 1, 17'd9, 4'hF, 32'h00000000, 0, 0, 0, 0, 0, 0);
    req(0, 0, 17'd9, 4'hF, 0, 32'h11BB33DD, 32'h10101010, 0, 0, 0, 0);
    req(1, 1, 17'd6, 4'h0, 32'h6666, 0, 0, 0, 0, 0, 0);
    req(1, 1, 17'd7, 4'h0, 32'h7777, 0, 0, 0, 0, 0, 0);
    req(1, 1, 17'd8, 4'h0, 32'h8888, 0, 0, 0, 0, 0, 0);
    req(1, 1, 17'd5, 4'h0, 32'hBEEF, 0, 0, 0, 0, 0, 0);
    req(1, 0, 17'd5, 4'hF, 0, 32'hBEEF, 32'h6666, 32'h7777, 32'h8888, 0, 0);
    req(1, 1, 17'd63, 4'h0, 32'h000A, 0, 0, 0, 0, 0, 0);
    req(1, 1, 17'd0, 4'h0, 32'h000B, 0, 0, 0, 0, 0, 0);
    req(1, 1, 17'd1, 4'h0, 32'h000C, 0, 0, 0, 0, 0, 0);
    req(1, 1, 17'd2, 4'h0, 32'h000D, 0, 0, 0, 0, 0, 0);
    req(1, 1, 17'd3, 4'h0, 32'h000E, 0, 0, 0, 0, 0, 0);
    req(1, 0, 17'd63, 4'hF, 0, 32'h000A, 32'h000B, 32'h000C, 32'h000D, 0, 0);
    req(1, 0, 17'h40, 4'hF, 0, 32'h000B, 32'h000C, 32'h000D, 32'h000E, 0, 0);
    req(1, 0, 17'd63, 4'hF, 0, 32'h000A, 32'h000B, 32'h000C, 32'h000D, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("a_leftover_expected", 32'(q[0].size()), 32'd0);
    chk("b_leftover_expected", 32'(q[1].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
